// File: rtl/line_raster_if.sv
// Pixel stream from the rasteriser toward the global memory write path.
interface line_raster_if #(
   parameter int COORD_W = 8
);
   logic                      pix_valid;
   logic                      pix_ready;
   logic signed [COORD_W-1:0] pix_x;
   logic signed [COORD_W-1:0] pix_y;
   logic                      pix_last;

   modport master (output pix_valid, output pix_x, output pix_y, output pix_last, input pix_ready);
   modport slave  (input pix_valid, input pix_x, input pix_y, input pix_last, output pix_ready);
endinterface

// File: rtl/line_raster.sv
// Bresenham line walker with screen-window clipping, streaming visible pixels
// over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for start; vertices latched on start
// SETUP | absolute deltas and step directions registered
// DRAW  | first cycle loads err, then one candidate pixel per step
// DONE  | one-cycle completion pulse
module line_raster #(
   parameter int COORD_W  = 8,
   parameter int SCREEN_W = 64,
   parameter int SCREEN_H = 64,
   parameter int CNT_W    = 10
) (
   input  logic                      c,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic signed [COORD_W-1:0] x0,
   input  logic signed [COORD_W-1:0] y0,
   input  logic signed [COORD_W-1:0] x1,
   input  logic signed [COORD_W-1:0] y1,
   output logic                      busy,
   output logic                      done,
   line_raster_if.master             pix,
   output logic [CNT_W-1:0]          pix_cnt
);
   localparam int W = COORD_W + 2;
   localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;
   state_t state, state_nx;

   logic signed [COORD_W-1:0] cur_x, cur_y, end_x, end_y;
   logic signed [W-1:0]       dx, dy, err, diff_x, diff_y, err_nx;
   logic signed [W:0]         e2, dx_w, dy_w;
   logic                      sx_neg, sy_neg, primed;
   logic                      vis, at_end, pvalid, handshake, advance, step_x, step_y;

   assign diff_x = $signed({{2{end_x[COORD_W-1]}}, end_x}) - $signed({{2{cur_x[COORD_W-1]}}, cur_x});
   assign diff_y = $signed({{2{end_y[COORD_W-1]}}, end_y}) - $signed({{2{cur_y[COORD_W-1]}}, cur_y});

   assign e2     = {err, 1'b0};
   assign dx_w   = {dx[W-1], dx};
   assign dy_w   = {dy[W-1], dy};
   assign step_x = (e2 > -dy_w);
   assign step_y = (e2 < dx_w);

   always_comb begin
      err_nx = err;
      if (step_x) err_nx = err_nx - dy;
      if (step_y) err_nx = err_nx + dx;
   end

   assign vis    = !cur_x[COORD_W-1] && (int'(cur_x) < SCREEN_W) &&
                   !cur_y[COORD_W-1] && (int'(cur_y) < SCREEN_H);
   assign at_end = (cur_x == end_x) && (cur_y == end_y);

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      pvalid    = 1'b0;
      handshake = 1'b0;
      advance   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_SETUP;
         end
         S_SETUP: begin
            busy     = 1'b1;
            state_nx = S_DRAW;
         end
         S_DRAW: begin
            busy      = 1'b1;
            pvalid    = primed && vis;
            handshake = pvalid && pix.pix_ready;
            // clipped candidates never wait for the consumer
            advance   = primed && (!vis || pix.pix_ready) && !abort;
            if (advance && at_end) state_nx = S_DONE;
         end
         S_DONE: begin
            busy     = 1'b1;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (abort && (state != S_IDLE)) state_nx = S_IDLE;
   end

   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         cur_x   <= '0;
         cur_y   <= '0;
         end_x   <= '0;
         end_y   <= '0;
         dx      <= '0;
         dy      <= '0;
         err     <= '0;
         sx_neg  <= 1'b0;
         sy_neg  <= 1'b0;
         primed  <= 1'b0;
         pix_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cur_x   <= x0;
                  cur_y   <= y0;
                  end_x   <= x1;
                  end_y   <= y1;
                  pix_cnt <= '0;
                  primed  <= 1'b0;
               end
            end
            S_SETUP: begin
               dx     <= diff_x[W-1] ? -diff_x : diff_x;
               dy     <= diff_y[W-1] ? -diff_y : diff_y;
               sx_neg <= diff_x[W-1];
               sy_neg <= diff_y[W-1];
            end
            S_DRAW: begin
               // err comes from the registered deltas so subtract/abs/subtract never chain in one cycle
               if (!primed) begin
                  err    <= dx - dy;
                  primed <= 1'b1;
               end else if (advance && !at_end) begin
                  err <= err_nx;
                  if (step_x) cur_x <= sx_neg ? cur_x - ONE : cur_x + ONE;
                  if (step_y) cur_y <= sy_neg ? cur_y - ONE : cur_y + ONE;
               end
               if (handshake && !abort && (pix_cnt != {CNT_W{1'b1}}))
                  pix_cnt <= pix_cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign pix.pix_valid = pvalid;
   assign pix.pix_x     = cur_x;
   assign pix.pix_y     = cur_y;
   assign pix.pix_last  = pvalid && at_end;
endmodule
